// File: rtl/tx_word_mux_pkg.sv
`default_nettype none
// ============================================================================
// Package : edm_tx_pkg
// Purpose : Shared constants, select codes, FSM state type and XGMII helper
//           functions for the transmit word multiplexer.
// Rev     : 1.0  initial release
// ============================================================================
package edm_tx_pkg;

  localparam int XGMII_DATA_W = 64;
  localparam int XGMII_CTRL_W = 8;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_REQ  = 2'b01;
  localparam logic [1:0] SEL_MEM  = 2'b10;
  localparam logic [1:0] SEL_NET  = 2'b11;

  localparam logic [63:0] IDLE_WORD  = 64'h0707_0707_0707_0707;
  localparam logic [7:0]  IDLE_CTRL  = 8'hFF;
  localparam logic [63:0] ERR_WORD   = 64'hFEFE_FEFE_FEFE_FEFE;
  localparam logic [7:0]  START_CHAR = 8'hFB;
  localparam logic [7:0]  TERM_CHAR  = 8'hFD;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_IN_FRAME  = 2'd1,
    ST_PREEMPTED = 2'd2
  } net_state_t;

  // Start is only legal in lane 0.
  function automatic logic is_start(input logic [63:0] d, input logic [7:0] c);
    return c[0] && (d[7:0] == START_CHAR);
  endfunction

  // Terminate may appear in any lane, but only as a control character.
  function automatic logic has_term(input logic [63:0] d, input logic [7:0] c);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (c[i] && (d[8*i +: 8] == TERM_CHAR)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Strobe pattern {netq, memq, reqq} implied by a select code.
  function automatic logic [2:0] expected_strobes(input logic [1:0] sel);
    logic [2:0] s;
    case (sel)
      SEL_REQ: s = 3'b001;
      SEL_MEM: s = 3'b010;
      SEL_NET: s = 3'b100;
      default: s = 3'b000;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_word_mux_if.sv
`default_nettype none
// ============================================================================
// Interface : tx_word_mux_if
// Purpose   : Arbiter/queue side inputs and XGMII side outputs of the
//             transmit word multiplexer.
//   master : drives sel, read strobes, queue outputs, tx_pause
//   slave  : the multiplexer; drives xgmii_txd/txc and tx_src
// Rev       : 1.0  initial release
// ============================================================================
interface tx_word_mux_if #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
);
  logic [1:0]               sel;
  logic                     memq_read;
  logic                     reqq_read;
  logic                     netq_read;
  logic [CTRL_W+DATA_W-1:0] memq_dout;
  logic [CTRL_W+DATA_W-1:0] reqq_dout;
  logic [CTRL_W+DATA_W-1:0] netq_dout;
  logic                     tx_pause;
  logic [DATA_W-1:0]        xgmii_txd;
  logic [CTRL_W-1:0]        xgmii_txc;
  logic [1:0]               tx_src;

  modport master (
    output sel, memq_read, reqq_read, netq_read,
    output memq_dout, reqq_dout, netq_dout, tx_pause,
    input  xgmii_txd, xgmii_txc, tx_src
  );

  modport slave (
    input  sel, memq_read, reqq_read, netq_read,
    input  memq_dout, reqq_dout, netq_dout, tx_pause,
    output xgmii_txd, xgmii_txc, tx_src
  );
endinterface
`default_nettype wire

// File: rtl/tx_word_mux_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Purpose : Saturating up-counter; holds at all-ones instead of wrapping.
//   clk, reset_n (async active-low), inc : increment request
//   o_count                              : current count
// Rev     : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             inc,
  output logic [CNT_W-1:0]      o_count
);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_count <= '0;
    end else if (inc && (o_count != '1)) begin
      o_count <= o_count + C_ONE;
    end
  end
endmodule
`default_nettype wire

// File: rtl/tx_word_mux.sv
`default_nettype none
// ============================================================================
// Module  : tx_word_mux
// Purpose : Aligns arbiter select/strobes with the one-cycle queue read
//           latency and drives one registered XGMII word per cycle (idle
//           when nothing is selected, error word on strobe inconsistency).
//           Tracks net-frame preemption and keeps per-source counters.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : tx_word_mux_if.slave (arbiter/queue in, XGMII out)
//   net_in_frame : net frame started and not yet terminated
//   sel_err      : sticky strobe/select inconsistency flag
//   *_cnt        : saturating statistics counters
// Rev     : 1.0  initial release
// ============================================================================
module tx_word_mux
  import edm_tx_pkg::*;
#(
  parameter int DATA_W = XGMII_DATA_W,
  parameter int CTRL_W = XGMII_CTRL_W,
  parameter int CNT_W  = 32
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  tx_word_mux_if.slave      bus,
  output logic              net_in_frame,
  output logic              sel_err,
  output logic [CNT_W-1:0]  mem_cnt,
  output logic [CNT_W-1:0]  req_cnt,
  output logic [CNT_W-1:0]  net_cnt,
  output logic [CNT_W-1:0]  preempt_cnt,
  output logic [CNT_W-1:0]  pause_cnt
);

  // Stage 1: select and consistency of the read cycle.
  logic [1:0]  r_sel_d1;
  logic        r_err_d1;
  logic [2:0]  w_strobes;

  assign w_strobes = {bus.netq_read, bus.memq_read, bus.reqq_read};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel_d1 <= SEL_NONE;
      r_err_d1 <= 1'b0;
    end else begin
      r_sel_d1 <= bus.sel;
      r_err_d1 <= (w_strobes != expected_strobes(bus.sel));
    end
  end

  // Stage 2: queue data is now valid; pick the word to emit.
  logic [DATA_W-1:0] w_txd;
  logic [CTRL_W-1:0] w_txc;
  logic [1:0]        w_src;

  always_comb begin
    w_txd = IDLE_WORD;
    w_txc = IDLE_CTRL;
    w_src = SEL_NONE;
    if (r_err_d1) begin
      w_txd = ERR_WORD;
    end else begin
      case (r_sel_d1)
        SEL_REQ: begin {w_txc, w_txd} = bus.reqq_dout; w_src = SEL_REQ; end
        SEL_MEM: begin {w_txc, w_txd} = bus.memq_dout; w_src = SEL_MEM; end
        SEL_NET: begin {w_txc, w_txd} = bus.netq_dout; w_src = SEL_NET; end
        default: ;
      endcase
    end
  end

  // Idle and error words both carry SEL_NONE, so they never touch the FSM
  // or the per-source counters.
  logic w_is_net, w_is_mr, w_start, w_term, w_preempt;
  assign w_is_net = (w_src == SEL_NET);
  assign w_is_mr  = (w_src == SEL_MEM) || (w_src == SEL_REQ);
  assign w_start  = is_start(w_txd, w_txc);
  assign w_term   = has_term(w_txd, w_txc);

  net_state_t r_state;
  assign w_preempt = (r_state == ST_IN_FRAME) && w_is_mr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.xgmii_txd <= IDLE_WORD;
      bus.xgmii_txc <= IDLE_CTRL;
      bus.tx_src    <= SEL_NONE;
      sel_err       <= 1'b0;
    end else begin
      bus.xgmii_txd <= w_txd;
      bus.xgmii_txc <= w_txc;
      bus.tx_src    <= w_src;
      if (r_err_d1) sel_err <= 1'b1;
    end
  end

  // Net-frame tracking; net_in_frame is registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      net_in_frame <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Start and terminate in one word leaves us idle.
          if (w_is_net && w_start && !w_term) begin
            r_state      <= ST_IN_FRAME;
            net_in_frame <= 1'b1;
          end
        end
        ST_IN_FRAME: begin
          if (w_is_mr) begin
            r_state <= ST_PREEMPTED;
          end else if (w_is_net && w_term) begin
            r_state      <= ST_IDLE;
            net_in_frame <= 1'b0;
          end
        end
        ST_PREEMPTED: begin
          if (w_is_net) begin
            if (w_term) begin
              r_state      <= ST_IDLE;
              net_in_frame <= 1'b0;
            end else begin
              r_state <= ST_IN_FRAME;
            end
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          net_in_frame <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_mem_cnt (
    .clk(clk), .reset_n(reset_n), .inc(w_src == SEL_MEM), .o_count(mem_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_req_cnt (
    .clk(clk), .reset_n(reset_n), .inc(w_src == SEL_REQ), .o_count(req_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_net_cnt (
    .clk(clk), .reset_n(reset_n), .inc(w_is_net), .o_count(net_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_preempt_cnt (
    .clk(clk), .reset_n(reset_n), .inc(w_preempt), .o_count(preempt_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_pause_cnt (
    .clk(clk), .reset_n(reset_n), .inc(bus.tx_pause), .o_count(pause_cnt));

endmodule
`default_nettype wire

// File: tb/tb_tx_word_mux.sv
`default_nettype none
// ============================================================================
// Module  : tb_tx_word_mux
// Purpose : Directed testbench for tx_word_mux with a scoreboard queue of
//           expected emitted words and status.
// Rev     : 1.0  initial release
// ============================================================================
module tb_tx_word_mux;
  import edm_tx_pkg::*;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  tx_word_mux_if #(.DATA_W(64), .CTRL_W(8)) bus ();

  logic             net_in_frame, sel_err;
  logic [CNT_W-1:0] mem_cnt, req_cnt, net_cnt, preempt_cnt, pause_cnt;

  tx_word_mux #(.DATA_W(64), .CTRL_W(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .net_in_frame(net_in_frame), .sel_err(sel_err),
    .mem_cnt(mem_cnt), .req_cnt(req_cnt), .net_cnt(net_cnt),
    .preempt_cnt(preempt_cnt), .pause_cnt(pause_cnt)
  );

  typedef struct {
    logic [63:0] txd;
    logic [7:0]  txc;
    logic [1:0]  src;
    logic        nif;
    logic        serr;
    int          mem, req, net, pre;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state
  int   m_st, m_mem, m_req, m_net, m_pre, m_pause;
  logic m_serr;
  logic [71:0] p_mem, p_req, p_net;

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  function automatic logic [71:0] junk();
    return {8'($urandom), $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_mem = 0; m_req = 0; m_net = 0; m_pre = 0; m_pause = 0;
    m_serr = 1'b0;
    p_mem = junk(); p_req = junk(); p_net = junk();
    bus.sel = SEL_NONE; bus.memq_read = 1'b0; bus.reqq_read = 1'b0;
    bus.netq_read = 1'b0; bus.tx_pause = 1'b0;
    bus.memq_dout = p_mem; bus.reqq_dout = p_req; bus.netq_dout = p_net;
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e.txd = IDLE_WORD; e.txc = IDLE_CTRL; e.src = SEL_NONE;
    e.nif = (m_st != 0); e.serr = m_serr;
    e.mem = m_mem; e.req = m_req; e.net = m_net; e.pre = m_pre;
    return e;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_txd"}, bus.xgmii_txd, IDLE_WORD);
    check({tag, "_txc"}, 64'(bus.xgmii_txc), 64'(IDLE_CTRL));
    check({tag, "_src"}, 64'(bus.tx_src), 64'd0);
    check({tag, "_nif"}, 64'(net_in_frame), 64'd0);
    check({tag, "_serr"}, 64'(sel_err), 64'd0);
    check({tag, "_cnts"}, 64'({mem_cnt, req_cnt, net_cnt, preempt_cnt, pause_cnt}), 64'd0);
  endtask

  // One clock: check the word due now, then drive this cycle's request.
  task automatic cycle(input logic [1:0] s, input logic mr, input logic rr,
                       input logic nr, input logic [71:0] word, input logic pause);
    exp_t e;
    logic [2:0] want;
    logic err, st, tm;
    @(posedge clk); #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("txd", bus.xgmii_txd, e.txd);
      check("txc", 64'(bus.xgmii_txc), 64'(e.txc));
      check("tx_src", 64'(bus.tx_src), 64'(e.src));
      check("net_in_frame", 64'(net_in_frame), 64'(e.nif));
      check("sel_err", 64'(sel_err), 64'(e.serr));
      check("mem_cnt", 64'(mem_cnt), 64'(e.mem));
      check("req_cnt", 64'(req_cnt), 64'(e.req));
      check("net_cnt", 64'(net_cnt), 64'(e.net));
      check("preempt_cnt", 64'(preempt_cnt), 64'(e.pre));
    end else begin
      check("scoreboard_empty", 64'(q.size()), 64'd1);
    end
    check("pause_cnt", 64'(pause_cnt), 64'(m_pause));

    // Data for last cycle's reads appears now.
    bus.memq_dout = p_mem; bus.reqq_dout = p_req; bus.netq_dout = p_net;
    p_mem = mr ? word : junk();
    p_req = rr ? word : junk();
    p_net = nr ? word : junk();
    bus.sel = s; bus.memq_read = mr; bus.reqq_read = rr; bus.netq_read = nr;
    bus.tx_pause = pause;
    if (pause) m_pause = sat(m_pause);

    case (s)
      2'b01:   want = 3'b001;
      2'b10:   want = 3'b010;
      2'b11:   want = 3'b100;
      default: want = 3'b000;
    endcase
    err = ({nr, mr, rr} != want);
    e = idle_exp();
    if (err) begin
      e.txd = 64'hFEFE_FEFE_FEFE_FEFE;
      m_serr = 1'b1;
    end else if (s != 2'b00) begin
      e.txd = word[63:0]; e.txc = word[71:64]; e.src = s;
      st = word[64] && (word[7:0] == 8'hFB);
      tm = 1'b0;
      for (int i = 0; i < 8; i++)
        if (word[64+i] && (word[8*i +: 8] == 8'hFD)) tm = 1'b1;
      if (s == 2'b11) begin
        m_net = sat(m_net);
        if (m_st == 0) m_st = (st && !tm) ? 1 : 0;
        else m_st = tm ? 0 : 1;
      end else begin
        if (s == 2'b10) m_mem = sat(m_mem); else m_req = sat(m_req);
        if (m_st == 1) begin m_st = 2; m_pre = sat(m_pre); end
      end
    end
    e.nif = (m_st != 0); e.serr = m_serr;
    e.mem = m_mem; e.req = m_req; e.net = m_net; e.pre = m_pre;
    q.push_back(e);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    q.delete();
    q.push_back(idle_exp());   // output from cleared pipeline
    q.push_back(idle_exp());   // output from the release cycle's "none"
  endtask

  localparam logic [71:0] W_MEM   = {8'h00, 64'h1122_3344_5566_7788};
  localparam logic [71:0] W_START = {8'h01, 64'hD555_5555_5555_55FB};
  localparam logic [71:0] W_ND1   = {8'h00, 64'hA1A2_A3A4_A5A6_A7A8};
  localparam logic [71:0] W_ND2   = {8'h00, 64'hB1B2_B3B4_B5B6_B7B8};
  localparam logic [71:0] W_REQ   = {8'h00, 64'hC0C1_C2C3_C4C5_C6C7};
  localparam logic [71:0] W_TERM  = {8'hF8, 64'h0707_0707_FDAA_BBCC};
  localparam logic [71:0] W_BOTH  = {8'h81, 64'hFD00_0000_0000_00FB};

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    release_reset();

    // Idle for 10 cycles
    repeat (10) cycle(SEL_NONE, 1'b0, 1'b0, 1'b0, junk(), 1'b0);

    // Single MEM read
    cycle(SEL_MEM, 1'b1, 1'b0, 1'b0, W_MEM, 1'b0);
    repeat (2) cycle(SEL_NONE, 1'b0, 1'b0, 1'b0, junk(), 1'b1);

    // Net frame preempted by one REQ word, then terminated
    cycle(SEL_NET, 1'b0, 1'b0, 1'b1, W_START, 1'b0);
    cycle(SEL_NET, 1'b0, 1'b0, 1'b1, W_ND1, 1'b1);
    cycle(SEL_NET, 1'b0, 1'b0, 1'b1, W_ND2, 1'b0);
    cycle(SEL_REQ, 1'b0, 1'b1, 1'b0, W_REQ, 1'b0);
    cycle(SEL_NET, 1'b0, 1'b0, 1'b1, W_TERM, 1'b0);
    repeat (3) cycle(SEL_NONE, 1'b0, 1'b0, 1'b0, junk(), 1'b0);

    // Start and terminate in the same word: stays idle
    cycle(SEL_NET, 1'b0, 1'b0, 1'b1, W_BOTH, 1'b0);
    // Back-to-back source alternation
    for (int i = 0; i < 3; i++) begin
      cycle(SEL_MEM, 1'b1, 1'b0, 1'b0, {8'h00, 32'hAAAA_0000, 32'(i)}, 1'b0);
      cycle(SEL_REQ, 1'b0, 1'b1, 1'b0, {8'h00, 32'hBBBB_0000, 32'(i)}, 1'b0);
      cycle(SEL_NET, 1'b0, 1'b0, 1'b1, {8'h00, 32'hCCCC_0000, 32'(i)}, 1'b0);
    end
    repeat (2) cycle(SEL_NONE, 1'b0, 1'b0, 1'b0, junk(), 1'b0);

    // Strobe/select inconsistencies; sel_err must stick
    cycle(SEL_MEM, 1'b1, 1'b0, 1'b1, W_MEM, 1'b0);
    repeat (3) cycle(SEL_NONE, 1'b0, 1'b0, 1'b0, junk(), 1'b0);
    cycle(SEL_NONE, 1'b0, 1'b1, 1'b0, W_REQ, 1'b0);
    cycle(SEL_NET, 1'b0, 1'b0, 1'b0, W_ND1, 1'b0);
    repeat (2) cycle(SEL_NONE, 1'b0, 1'b0, 1'b0, junk(), 1'b0);

    // Saturation: 20 net data words with pause held high
    repeat (20) cycle(SEL_NET, 1'b0, 1'b0, 1'b1, {8'h00, $urandom, $urandom}, 1'b1);
    repeat (3) cycle(SEL_NONE, 1'b0, 1'b0, 1'b0, junk(), 1'b0);

    // Enter PREEMPTED, then asynchronous reset mid-frame
    cycle(SEL_NET, 1'b0, 1'b0, 1'b1, W_START, 1'b0);
    cycle(SEL_REQ, 1'b0, 1'b1, 1'b0, W_REQ, 1'b0);
    cycle(SEL_MEM, 1'b1, 1'b0, 1'b0, W_MEM, 1'b0);
    repeat (3) cycle(SEL_NONE, 1'b0, 1'b0, 1'b0, junk(), 1'b0);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    model_reset();
    release_reset();
    repeat (4) cycle(SEL_NONE, 1'b0, 1'b0, 1'b0, junk(), 1'b0);
    cycle(SEL_MEM, 1'b1, 1'b0, 1'b0, W_MEM, 1'b0);
    repeat (3) cycle(SEL_NONE, 1'b0, 1'b0, 1'b0, junk(), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
